// File: rtl/popcount_window_accum.sv
`default_nettype none
// ============================================================================
// Module      : popcount_window_accum
// Description : Window accumulator placed after the 4-input population-count
//               encoder. Accepts one-hot encoded counts (v=0, w=1, x=2, y=3,
//               z=4 ones) over a valid/ready handshake, sums WINDOW decoded
//               samples, then presents the window total on a held output
//               handshake until the consumer takes it.
//
// Parameters  : WINDOW    samples per window (>= 2)
//               SUM_W     width of the window total (2**SUM_W > 4*WINDOW)
//
// Ports       : clk        single clock, rising-edge
//               rst        asynchronous active-high reset
//               in_valid   upstream sample valid
//               in_ready   block can accept a sample (state decode)
//               v,w,x,y,z  one-hot count from the encoder
//               out_valid  window total available (state decode)
//               out_ready  downstream accepts the total
//               out_sum    window total, 0 .. 4*WINDOW
//               out_err    malformed sample seen in this window
//
// Build option: POPCOUNT_ONEHOT_CHECK_EN
//               defined   -> samples whose bit count is not exactly one
//                            contribute 0 and raise out_err for the window
//               undefined -> priority decode z>y>x>w>v, out_err tied to 0
//
// Revision    : 1.0  initial release
// ============================================================================
module popcount_window_accum #(
   parameter int WINDOW = 8,
   parameter int SUM_W  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             v,
   input  logic             w,
   input  logic             x,
   input  logic             y,
   input  logic             z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic             out_err
);

   // Sample counter only needs to reach WINDOW-1 before the window closes.
   localparam int                c_cnt_w = $clog2(WINDOW);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WINDOW - 1);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [c_cnt_w-1:0]   r_count;
   logic [SUM_W-1:0]     r_acc;
   logic [SUM_W-1:0]     r_out_sum;

   logic                 w_accept;
   logic                 w_last;
   logic                 w_release;
   logic [2:0]           w_val;
   logic [SUM_W-1:0]     w_acc_nxt;

   // -------------------------------------------------------------------------
   // Handshake decodes: purely from registered state, so there is no
   // combinational path from in_valid or out_ready to either ready/valid.
   // -------------------------------------------------------------------------
   assign in_ready  = (r_state == ST_ACCUM);
   assign out_valid = (r_state == ST_HOLD);

   assign w_accept  = in_valid & in_ready;
   assign w_last    = w_accept & (r_count == c_last);
   assign w_release = out_valid & out_ready;

   // -------------------------------------------------------------------------
   // Sample decode
   // -------------------------------------------------------------------------
`ifdef POPCOUNT_ONEHOT_CHECK_EN
   logic w_bad;

   // Only an exact one-hot pattern is a legal encoder output; anything else
   // counts toward the window with value 0 and marks the window as bad.
   always_comb begin
      w_val = 3'd0;
      w_bad = 1'b0;
      case ({z, y, x, w, v})
         5'b00001: w_val = 3'd0;
         5'b00010: w_val = 3'd1;
         5'b00100: w_val = 3'd2;
         5'b01000: w_val = 3'd3;
         5'b10000: w_val = 3'd4;
         default:  w_bad = 1'b1;
      endcase
   end
`else
   // Without checking, the highest asserted line wins; all-zero decodes to 0.
   always_comb begin
      w_val = 3'd0;
      casez ({z, y, x, w, v})
         5'b1????: w_val = 3'd4;
         5'b01???: w_val = 3'd3;
         5'b001??: w_val = 3'd2;
         5'b0001?: w_val = 3'd1;
         5'b00001: w_val = 3'd0;
         default:  w_val = 3'd0;
      endcase
   end
`endif

   // The SUM_W constraint guarantees this sum never wraps within a window.
   assign w_acc_nxt = r_acc + SUM_W'(w_val);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACCUM: begin
            if (w_last) begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               w_state_nxt = ST_ACCUM;
            end
         end
         default: begin
            w_state_nxt = ST_ACCUM;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Window datapath. Counter and accumulator are cleared when the held
   // total is released rather than at close, so the first sample of the
   // next window can only be taken the cycle after HOLD exits.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count   <= '0;
         r_acc     <= '0;
         r_out_sum <= '0;
      end else if (w_accept) begin
         r_count <= r_count + c_cnt_w'(1);
         r_acc   <= w_acc_nxt;
         if (w_last) begin
            r_out_sum <= w_acc_nxt;
         end
      end else if (w_release) begin
         r_count <= '0;
         r_acc   <= '0;
      end
   end

   assign out_sum = r_out_sum;

   // -------------------------------------------------------------------------
   // Integrity flag
   // -------------------------------------------------------------------------
`ifdef POPCOUNT_ONEHOT_CHECK_EN
   logic r_err;
   logic r_out_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err     <= 1'b0;
         r_out_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= r_err | w_bad;
         // The closing sample's own status is folded into the reported flag.
         if (w_last) begin
            r_out_err <= r_err | w_bad;
         end
      end else if (w_release) begin
         r_err <= 1'b0;
      end
   end

   assign out_err = r_out_err;
`else
   assign out_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_popcount_window_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_window_accum
// Description : Scoreboard bench for popcount_window_accum (WINDOW=4,
//               SUM_W=5). A reference model of the window rules pushes the
//               expected total per closed window; a monitor compares on each
//               rising out_valid and checks handshake/hold behaviour every
//               cycle. Directed scenarios are followed by random traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_popcount_window_accum;
   localparam int WINDOW = 4;
   localparam int SUM_W  = 5;

   localparam logic [4:0] S_V = 5'b00001;
   localparam logic [4:0] S_W = 5'b00010;
   localparam logic [4:0] S_X = 5'b00100;
   localparam logic [4:0] S_Y = 5'b01000;
   localparam logic [4:0] S_Z = 5'b10000;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             v, w, x, y, z;
   logic             out_valid;
   logic             out_ready;
   logic [SUM_W-1:0] out_sum;
   logic             out_err;

   popcount_window_accum #(.WINDOW(WINDOW), .SUM_W(SUM_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .v(v), .w(w), .x(x), .y(y), .z(z),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_err(out_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [SUM_W-1:0] sum;
      logic             err;
   } exp_t;
   exp_t sbq[$];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Value of a sample by the encoder meaning: bit i of {z,y,x,w,v} means i ones.
   function automatic int sample_value(input logic [4:0] b, output bit bad);
      bad = 1'b0;
`ifdef POPCOUNT_ONEHOT_CHECK_EN
      if ($countones(b) != 1) begin
         bad = 1'b1;
         return 0;
      end
`endif
      for (int i = 4; i >= 0; i--) if (b[i]) return i;
      return 0;
   endfunction

   // ------------------------------------------------------------------------
   // Reference model: window bookkeeping with plain integers
   // ------------------------------------------------------------------------
   bit m_hold;
   int m_cnt, m_sum, m_last_sum;
   bit m_err, m_last_err;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hold = 0; m_cnt = 0; m_sum = 0; m_err = 0;
         m_last_sum = 0; m_last_err = 0;
         sbq.delete();
      end else if (m_hold) begin
         if (out_ready) begin
            m_hold = 0; m_cnt = 0; m_sum = 0; m_err = 0;
         end
      end else if (in_valid) begin
         bit bad;
         int val;
         exp_t e;
         val = sample_value({z, y, x, w, v}, bad);
         m_sum += val;
         m_err |= bad;
         m_cnt++;
         if (m_cnt == WINDOW) begin
            e.sum = m_sum[SUM_W-1:0];
            e.err = m_err;
            sbq.push_back(e);
            m_last_sum = m_sum;
            m_last_err = m_err;
            m_hold = 1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Monitor: sampled on the falling edge
   // ------------------------------------------------------------------------
   bit prev_valid = 0;

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 0;
      end else begin
         check("in_ready", int'(in_ready), int'(!m_hold));
         check("out_valid", int'(out_valid), int'(m_hold));
         if (out_valid && !prev_valid) begin
            if (sbq.size() == 0) begin
               check("unexpected_window", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("window_sum", int'(out_sum), int'(e.sum));
               check("window_err", int'(out_err), int'(e.err));
            end
         end
         check("held_sum", int'(out_sum), m_last_sum);
         check("held_err", int'(out_err), int'(m_last_err));
         prev_valid = out_valid;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic send(input logic [4:0] b);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      {z, y, x, w, v} = b;
      while (!in_ready) begin
         if (++t > 50) begin
            check("send_timeout", 1, 0);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic send4(input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] d);
      send(a); send(b); send(c); send(d);
      idle(1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      {z, y, x, w, v} = 5'b0;

      // Reset with no clock edge yet
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready",  int'(in_ready), 1);
      check("rst_out_sum",   int'(out_sum), 0);
      check("rst_out_err",   int'(out_err), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Back-to-back w,x,y,z with out_ready high
      out_ready = 1'b1;
      send4(S_W, S_X, S_Y, S_Z);
      check("b2b_valid", int'(out_valid), 1);
      check("b2b_sum",   int'(out_sum), 10);
      check("b2b_err",   int'(out_err), 0);
      check("b2b_ready", int'(in_ready), 0);
      @(negedge clk);
      check("b2b_ready_next", int'(in_ready), 1);

      // Four z with consumer stalled while upstream keeps offering
      out_ready = 1'b0;
      send(S_Z); send(S_Z); send(S_Z); send(S_Z);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; {z, y, x, w, v} = S_Y;
      end
      check("stall_sum",   int'(out_sum), 16);
      check("stall_valid", int'(out_valid), 1);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("stall_release", int'(in_ready), 1);
      send4(S_V, S_V, S_V, S_V);
      check("zero_sum", int'(out_sum), 0);

      // Malformed sample in the middle
      send4(S_X, 5'b00011, S_X, S_X);
`ifdef POPCOUNT_ONEHOT_CHECK_EN
      check("bad_sum", int'(out_sum), 6);
      check("bad_err", int'(out_err), 1);
`else
      check("bad_sum", int'(out_sum), 7);
      check("bad_err", int'(out_err), 0);
`endif
      idle(1);

      // Gapped input
      send(S_Y); idle(1); send(S_Y); idle(1); send(S_W); idle(1); send(S_V);
      idle(1);
      check("gap_sum", int'(out_sum), 7);
      idle(1);

      // Async reset mid-window
      send(S_X); send(S_X); idle(1);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_in_ready",  int'(in_ready), 1);
      check("arst_out_sum",   int'(out_sum), 0);
      check("arst_out_err",   int'(out_err), 0);
      #1 rst = 1'b0;
      send4(S_W, S_W, S_W, S_W);
      check("post_rst_sum", int'(out_sum), 4);
      idle(2);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0)
            {z, y, x, w, v} = 5'($urandom);
         else
            {z, y, x, w, v} = 5'(1 << $urandom_range(0, 4));
      end

      // Drain
      in_valid = 1'b0; out_ready = 1'b1;
      idle(4);
      check("sb_empty", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
